// File: rtl/cal_pkg.sv
// Shared opcodes, state encoding and constants for the 4-bit calculator
// sequencing controller.
package cal_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [7:0] DIV0_RESULT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } cal_state_t;

endpackage

// File: rtl/cal_add.sv
// 4-bit adder with carry out.
module cal_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] sum,
  output logic       carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/cal_div_step.sv
// One combinational iteration of a restoring divider.
module cal_div_step (
  input  logic [4:0] r,
  input  logic [3:0] q,
  input  logic [3:0] b,
  output logic [4:0] r_nx,
  output logic [3:0] q_nx
);

  logic [4:0] r_sh;
  logic [3:0] q_sh;

  always_comb begin
    r_sh = {r[3:0], q[3]};
    q_sh = {q[2:0], 1'b0};
    r_nx = r_sh;
    q_nx = q_sh;
    if (r_sh >= {1'b0, b}) begin
      r_nx = r_sh - {1'b0, b};
      q_nx = {q_sh[3:1], 1'b1};
    end
  end

endmodule

// File: rtl/cal_mul.sv
// 4x4 unsigned multiplier with 8-bit product.
module cal_mul (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] prod
);

  assign prod = {4'b0, a} * {4'b0, b};

endmodule

// File: rtl/cal_sub.sv
// 4-bit subtractor; borrow is set when a < b.
module cal_sub (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] diff,
  output logic       borrow
);

  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/cal_ctrl.sv
// Calculator sequencer: accepts one op, runs add/sub/mul or the iterative
// divider, and holds the 8-bit result until the consumer takes it.
module cal_ctrl
  import cal_pkg::*;
#(
  parameter int MUL_STAGES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] result,
  output logic       flag,
  output logic       busy
);

  localparam logic [1:0] MUL_LAST = 2'(MUL_STAGES - 1);

  cal_state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [4:0] r_q, r_d;
  logic [3:0] qt_q, qt_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] res_q, res_d;
  logic       flag_q, flag_d;

  logic [3:0] sum, diff;
  logic       carry, borrow;
  logic [7:0] prod;
  logic [4:0] r_nx;
  logic [3:0] q_nx;

  cal_add u_add (.a(a_q), .b(b_q), .sum(sum), .carry(carry));
  cal_sub u_sub (.a(a_q), .b(b_q), .diff(diff), .borrow(borrow));
  cal_mul u_mul (.a(a_q), .b(b_q), .prod(prod));

  cal_div_step u_step (
    .r   (r_q),
    .q   (qt_q),
    .b   (b_q),
    .r_nx(r_nx),
    .q_nx(q_nx)
  );

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = res_q;
  assign flag      = flag_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    qt_d    = qt_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    flag_d  = flag_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_d  = op;
          a_d   = a;
          b_d   = b;
          r_d   = 5'd0;
          qt_d  = a;
          cnt_d = 2'd0;
          state_d = (op == OP_DIV && b != 4'd0) ? DIV : EXEC;
        end
      end
      EXEC: begin
        // Only MUL may dwell here; everything else captures at once.
        if (op_q != OP_MUL || cnt_q == MUL_LAST) begin
          cnt_d   = 2'd0;
          state_d = DONE;
          unique case (op_q)
            OP_ADD: begin
              res_d  = {3'b0, carry, sum};
              flag_d = carry;
            end
            OP_SUB: begin
              res_d  = {4'b0, diff};
              flag_d = borrow;
            end
            OP_MUL: begin
              res_d  = prod;
              flag_d = 1'b0;
            end
            default: begin
              res_d  = DIV0_RESULT;
              flag_d = 1'b1;
            end
          endcase
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DIV: begin
        r_d  = r_nx;
        qt_d = q_nx;
        if (cnt_q == 2'd3) begin
          res_d   = {r_nx[3:0], q_nx};
          flag_d  = 1'b0;
          cnt_d   = 2'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 2'd0;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      r_q     <= 5'd0;
      qt_q    <= 4'd0;
      cnt_q   <= 2'd0;
      res_q   <= 8'h00;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      qt_q    <= qt_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flag_q  <= flag_d;
    end
  end

endmodule
